// File: rtl/sound_event_arbiter.sv
// Fixed-priority arbiter sharing one tone generator between game audio events.
// Optional preemption of a playing tone by a higher-index request: define SND_PREEMPT_EN.
module sound_event_arbiter #(
  parameter int N_REQ       = 3,
  parameter int TONE_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 1000000,
  parameter int CNT_W       = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             mute,
  output logic             aud_en,
  output logic [1:0]       tone_sel,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] pending,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;

  logic [N_REQ-1:0] win_mask;
  logic [1:0]       win_idx;
  logic             any_pend;
  logic             preempt;
  logic             do_grant;

  // A source wins when it is pending and nothing above it is.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_win
      assign win_mask[gi] = pending[gi] && ((pending >> (gi + 1)) == '0);
    end
  endgenerate

  assign any_pend = |pending;

  always_comb begin
    win_idx = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_mask[i]) win_idx = 2'(i);
    end
  end

`ifdef SND_PREEMPT_EN
  assign preempt = (state == PLAY) && any_pend && (win_idx > tone_sel);
`else
  assign preempt = 1'b0;
`endif

  assign do_grant = any_pend &&
                    ((state == IDLE) ||
                     (state == GAP && counter == '0) ||
                     preempt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      aud_en   <= 1'b0;
      tone_sel <= 2'd0;
      grant    <= '0;
      pending  <= '0;
      busy     <= 1'b0;
    end else if (mute) begin
      state   <= IDLE;
      counter <= '0;
      aud_en  <= 1'b0;
      grant   <= '0;
      pending <= '0;
      busy    <= 1'b0;
    end else begin
      // A request arriving on its own grant cycle survives the clear.
      pending <= (pending & ~(do_grant ? win_mask : '0)) | req;
      grant   <= '0;
      if (do_grant) begin
        state    <= PLAY;
        counter  <= TONE_LOAD;
        aud_en   <= 1'b1;
        busy     <= 1'b1;
        tone_sel <= win_idx;
        grant    <= win_mask;
      end else begin
        case (state)
          PLAY: begin
            if (counter == '0) begin
              state   <= GAP;
              counter <= GAP_LOAD;
              aud_en  <= 1'b0;
            end else begin
              counter <= counter - 1'b1;
            end
          end
          GAP: begin
            if (counter == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              counter <= counter - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Bench for sound_event_arbiter: directed scenarios then random traffic against a tone/gap model.
module tb_sound_event_arbiter;

  localparam int N = 3;
  localparam int T = 8;
  localparam int G = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         mute;
  logic [N-1:0] req;
  logic         aud_en;
  logic [1:0]   tone_sel;
  logic [N-1:0] grant;
  logic [N-1:0] pending;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  // Model state: remaining high cycles of the tone and remaining silent cycles.
  logic [N-1:0] m_pending;
  logic [N-1:0] m_grant;
  logic [1:0]   m_sel;
  int           tone_left;
  int           gap_left;

  always #5 clk = ~clk;

  sound_event_arbiter #(
    .N_REQ(N), .TONE_CYCLES(T), .GAP_CYCLES(G), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .mute(mute),
    .aud_en(aud_en), .tone_sel(tone_sel), .grant(grant),
    .pending(pending), .busy(busy)
  );

  function automatic int top_idx(input logic [N-1:0] p);
    int r = -1;
    for (int i = 0; i < N; i++) if (p[i]) r = i;
    return r;
  endfunction

  task automatic start_tone();
    int w;
    w = top_idx(m_pending);
    m_grant = N'(1 << w);
    m_sel = 2'(w);
    m_pending[w] = 1'b0;
    tone_left = T;
    gap_left = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic m, input logic rs);
    m_grant = '0;
    if (rs) begin
      m_pending = '0; m_sel = 2'd0; tone_left = 0; gap_left = 0;
    end else if (m) begin
      m_pending = '0; tone_left = 0; gap_left = 0;
    end else begin
      if (tone_left > 0) begin
`ifdef SND_PREEMPT_EN
        if (top_idx(m_pending) > int'(m_sel)) start_tone();
        else begin
          tone_left--;
          if (tone_left == 0) gap_left = G;
        end
`else
        tone_left--;
        if (tone_left == 0) gap_left = G;
`endif
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0 && m_pending != '0) start_tone();
      end else if (m_pending != '0) begin
        start_tone();
      end
      m_pending = m_pending | r;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic m, input logic rs);
    req = r; mute = m; reset = rs;
    @(posedge clk);
    model_edge(r, m, rs);
    #1;
    chk("aud_en",   4'(aud_en),   4'(tone_left > 0));
    chk("busy",     4'(busy),     4'((tone_left > 0) || (gap_left > 0)));
    chk("grant",    4'(grant),    4'(m_grant));
    chk("pending",  4'(pending),  4'(m_pending));
    chk("tone_sel", 4'(tone_sel), 4'(m_sel));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b0, 1'b0);
  endtask

  initial begin
    req = '0; mute = 1'b0; reset = 1'b1;
    m_pending = '0; m_grant = '0; m_sel = 2'd0; tone_left = 0; gap_left = 0;
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);

    // Single low-priority tone with full gap.
    cycle(3'b001, 1'b0, 1'b0);
    idle(16);

    // All three at once: served 2, 1, 0.
    cycle(3'b111, 1'b0, 1'b0);
    idle(40);

    // Coalescing while pending, then a repeat on the grant cycle.
    cycle(3'b100, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      cycle(3'b010, 1'b0, 1'b0);
      idle(1);
    end
    idle(30);
    cycle(3'b010, 1'b0, 1'b0);
    cycle(3'b010, 1'b0, 1'b0);
    idle(30);

    // Mute on the third PLAY cycle with two requests still queued.
    cycle(3'b111, 1'b0, 1'b0);
    idle(3);
    cycle(3'b001, 1'b1, 1'b0);
    idle(3);
    cycle(3'b001, 1'b0, 1'b0);
    idle(16);

    // Reset during GAP with a queued request.
    cycle(3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 20 && gap_left == 0; i++) idle(1);
    cycle(3'b100, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1);
    idle(20);

    // Higher request arriving on PLAY cycle 2.
    cycle(3'b001, 1'b0, 1'b0);
    idle(2);
    cycle(3'b100, 1'b0, 1'b0);
    idle(30);

    // Random traffic with occasional mute and reset.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      logic m, rs;
      r  = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      m  = ($urandom_range(0, 80) == 0);
      rs = ($urandom_range(0, 200) == 0);
      cycle(r, m, rs);
    end
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
